// File: rtl/isa_pkg.sv
// Shared ISA definitions: op classes, opcode prefixes, field positions, loader FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package isa_pkg;

  // Instruction word width consumed by the controller
  localparam int INSTR_W = 19;

  // op_class encodings; anything above OPC_STORE is illegal
  localparam logic [2:0] OPC_ALU_RR = 3'd0;
  localparam logic [2:0] OPC_ALU_RI = 3'd1;
  localparam logic [2:0] OPC_SHIFT  = 3'd2;
  localparam logic [2:0] OPC_LOAD   = 3'd3;
  localparam logic [2:0] OPC_STORE  = 3'd4;

  // Opcode prefixes: ALU forms use a 2-bit prefix, shift/memory a 3-bit one
  localparam logic [1:0] PFX_ALU_RR = 2'b00;
  localparam logic [1:0] PFX_ALU_RI = 2'b01;
  localparam logic [2:0] PFX_SHIFT  = 3'b110;
  localparam logic [2:0] PFX_MEM    = 3'b100;

  // Memory sub-codes following the 3-bit memory prefix
  localparam logic [1:0] SUB_LOAD  = 2'b00;
  localparam logic [1:0] SUB_STORE = 2'b01;

  // Field bit positions inside the 19-bit word
  localparam int P2_HI  = 18;  // 2-bit prefix
  localparam int P2_LO  = 17;
  localparam int P3_HI  = 18;  // 3-bit prefix
  localparam int P3_LO  = 16;
  localparam int FN_HI  = 16;  // 3-bit ALU function
  localparam int FN_LO  = 14;
  localparam int SUB_HI = 15;  // shift fn[1:0] or memory sub-code
  localparam int SUB_LO = 14;
  localparam int RD_HI  = 13;  // rd, or rs2 for STORE
  localparam int RD_LO  = 11;
  localparam int RS1_HI = 10;
  localparam int RS1_LO = 8;
  localparam int RS2_HI = 7;   // rs2 in register-register form
  localparam int RS2_LO = 5;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } ld_state_t;

endpackage

// File: rtl/instr_encoder.sv
// Purpose: packs decoded instruction fields into the 19-bit controller word.
// Latency: combinational.
// Backpressure: none; legal=0 flags op_class 5..7 (word forced to zero).
// Ports: i fields op_class/fn/rd/rs1/rs2/imm; o word[18:0], legal.
module instr_encoder
  import isa_pkg::*;
(
  input  logic [2:0]         op_class,
  input  logic [2:0]         fn,
  input  logic [2:0]         rd,
  input  logic [2:0]         rs1,
  input  logic [2:0]         rs2,
  input  logic [7:0]         imm,
  output logic [INSTR_W-1:0] word,
  output logic               legal
);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (op_class)
      OPC_ALU_RR: begin
        word[P2_HI:P2_LO]   = PFX_ALU_RR;
        word[FN_HI:FN_LO]   = fn;
        word[RD_HI:RD_LO]   = rd;
        word[RS1_HI:RS1_LO] = rs1;
        word[RS2_HI:RS2_LO] = rs2;
      end
      OPC_ALU_RI: begin
        word[P2_HI:P2_LO]   = PFX_ALU_RI;
        word[FN_HI:FN_LO]   = fn;
        word[RD_HI:RD_LO]   = rd;
        word[RS1_HI:RS1_LO] = rs1;
        word[IMM_HI:IMM_LO] = imm;
      end
      OPC_SHIFT: begin
        word[P3_HI:P3_LO]   = PFX_SHIFT;
        word[SUB_HI:SUB_LO] = fn[1:0];
        word[RD_HI:RD_LO]   = rd;
        word[RS1_HI:RS1_LO] = rs1;
        word[IMM_HI:IMM_LO] = imm;
      end
      OPC_LOAD: begin
        word[P3_HI:P3_LO]   = PFX_MEM;
        word[SUB_HI:SUB_LO] = SUB_LOAD;
        word[RD_HI:RD_LO]   = rd;
        word[RS1_HI:RS1_LO] = rs1;
        word[IMM_HI:IMM_LO] = imm;
      end
      OPC_STORE: begin
        // STORE has no destination; its data register sits in the rd slot
        word[P3_HI:P3_LO]   = PFX_MEM;
        word[SUB_HI:SUB_LO] = SUB_STORE;
        word[RD_HI:RD_LO]   = rs2;
        word[RS1_HI:RS1_LO] = rs1;
        word[IMM_HI:IMM_LO] = imm;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_loader.sv
// Purpose: fills instruction memory from a host field stream, then releases the CPU.
// Latency: memory write strobe/addr/data registered, one cycle after the handshake.
// Backpressure: in_ready low outside LOAD and once DEPTH words are written.
// Ports: clock/rst_n; load_start/load_done session control; in_valid/in_ready + fields;
//        imem_we/addr/wdata write port; word_count/full/err_illegal status; cpu_hold/cpu_start.
module instr_loader
  import isa_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               load_start,
  input  logic               load_done,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op_class,
  input  logic [2:0]         fn,
  input  logic [2:0]         rd,
  input  logic [2:0]         rs1,
  input  logic [2:0]         rs2,
  input  logic [7:0]         imm,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic [ADDR_W:0]    word_count,
  output logic               full,
  output logic               err_illegal,
  output logic               cpu_hold,
  output logic               cpu_start
);

  ld_state_t          r_state;
  logic [ADDR_W:0]    r_count;   // doubles as the next write address
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [INSTR_W-1:0] r_wdata;
  logic               r_err;
  logic               r_hold;
  logic               r_start;

  logic [INSTR_W-1:0] w_word;
  logic               w_legal;
  logic               w_full;
  logic               w_ready;
  logic               w_hs;

  instr_encoder u_enc (
    .op_class (op_class),
    .fn       (fn),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .imm      (imm),
    .word     (w_word),
    .legal    (w_legal)
  );

  // Count stops at DEPTH: that value is never used as a write address
  assign w_full  = (r_count == (ADDR_W+1)'(DEPTH));
  assign w_ready = (r_state == S_LOAD) && !w_full;
  assign w_hs    = in_valid && w_ready;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_hold  <= 1'b1;
      r_start <= 1'b0;
    end else begin
      r_we    <= 1'b0;
      r_start <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (load_start) begin
            r_state <= S_LOAD;
            r_count <= '0;
            r_err   <= 1'b0;
            r_hold  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (w_hs) begin
            if (w_legal) begin
              r_we    <= 1'b1;
              r_addr  <= r_count[ADDR_W-1:0];
              r_wdata <= w_word;
              r_count <= r_count + 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
          // A coincident handshake is still taken above before leaving LOAD
          if (load_done) r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          r_state <= S_DONE;
          r_hold  <= 1'b0;
          r_start <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = w_ready;
  assign imem_we     = r_we;
  assign imem_addr   = r_addr;
  assign imem_wdata  = r_wdata;
  assign word_count  = r_count;
  assign full        = w_full;
  assign err_illegal = r_err;
  assign cpu_hold    = r_hold;
  assign cpu_start   = r_start;

endmodule
